// File: rtl/mat_systolic_array_if.sv
// Weight-row load/swap and vector-stream bundle for mat_systolic_array.
interface mat_systolic_array_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(N);

    logic                    weight_valid;
    logic                    weight_ready;
    logic [N*DATA_WIDTH-1:0] weight_row;
    logic                    weight_swap;
    logic                    weights_loaded;
    logic                    data_valid_in;
    logic                    data_ready_in;
    logic [N*DATA_WIDTH-1:0] data_in;
    logic                    data_valid_out;
    logic [N*ACC_WIDTH-1:0]  data_out;

    modport master (
        output weight_valid,
        output weight_row,
        output weight_swap,
        output data_valid_in,
        output data_in,
        input  weight_ready,
        input  weights_loaded,
        input  data_ready_in,
        input  data_valid_out,
        input  data_out
    );

    modport slave (
        input  weight_valid,
        input  weight_row,
        input  weight_swap,
        input  data_valid_in,
        input  data_in,
        output weight_ready,
        output weights_loaded,
        output data_ready_in,
        output data_valid_out,
        output data_out
    );
endinterface

// File: rtl/mat_systolic_array.sv
// Weight-stationary NxN systolic array, y = x * W, shadow/active weight swap.
// Define MAT_SYSTOLIC_SAT_EN to clamp results to the DATA_WIDTH signed range.
module mat_systolic_array #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic                 clock,
    input logic                 reset_n,
    mat_systolic_array_if.slave bus
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(N);
    localparam int CW        = $clog2(N + 1);
    localparam int FW        = $clog2(2 * N + 1);
    localparam int LAT       = 2 * N;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
    typedef logic signed [DATA_WIDTH-1:0]   elem_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;

`ifdef MAT_SYSTOLIC_SAT_EN
    localparam acc_t SAT_HI =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam acc_t SAT_LO =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    function automatic acc_t clip(input acc_t v);
`ifdef MAT_SYSTOLIC_SAT_EN
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
`endif
        return v;
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          shd_cnt;
    logic [CW-1:0]          w_idx;
    logic [FW-1:0]          inflight;
    logic                   loaded;
    elem_t                  w_shd [N][N];
    elem_t                  w_act [N][N];
    logic [LAT-1:0]         vpipe;
    logic                   valid_q;
    logic [N*ACC_WIDTH-1:0] dout_q;

    logic w_ready, w_fire, d_ready, d_fire, do_swap;

    elem_t x_in  [N][N];
    acc_t  p_out [N][N];
    acc_t  y_col [N];

    assign w_ready = shd_cnt < CW'(N);
    assign w_fire  = bus.weight_valid && w_ready;
    assign d_fire  = bus.data_valid_in && d_ready;
    assign w_idx   = do_swap ? '0 : shd_cnt;

    assign bus.weight_ready   = w_ready;
    assign bus.weights_loaded = loaded;
    assign bus.data_ready_in  = d_ready;
    assign bus.data_valid_out = valid_q;
    assign bus.data_out       = dout_q;

    always_comb begin
        state_d = state_q;
        d_ready = 1'b0;
        do_swap = 1'b0;
        unique case (state_q)
            RUN: begin
                d_ready = loaded;
                if (bus.weight_swap && shd_cnt == CW'(N))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0)
                    state_d = SWAP;
            end
            SWAP: begin
                do_swap = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Rows landing in the swap cycle start the freshly cleared shadow set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            shd_cnt <= '0;
            loaded  <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_shd[r][c] <= '0;
                    w_act[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (do_swap)
                shd_cnt <= w_fire ? CW'(1) : '0;
            else if (w_fire)
                shd_cnt <= shd_cnt + CW'(1);
            for (int r = 0; r < N; r++) begin
                if (w_fire && w_idx == CW'(r)) begin
                    for (int c = 0; c < N; c++)
                        w_shd[r][c] <=
                            bus.weight_row[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (do_swap) begin
                loaded <= 1'b1;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++)
                        w_act[r][c] <= w_shd[r][c];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            vpipe    <= '0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            inflight <= inflight + FW'(d_fire) - FW'(valid_q);
            vpipe    <= {vpipe[LAT-2:0], d_fire};
            valid_q  <= vpipe[LAT-1];
            if (vpipe[LAT-1]) begin
                for (int j = 0; j < N; j++)
                    dout_q[j*ACC_WIDTH +: ACC_WIDTH] <= clip(y_col[j]);
            end
        end
    end

    // Row i enters i cycles late so partial sums meet their operands.
    for (genvar i = 0; i < N; i++) begin : g_row
        elem_t sk [i+1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k <= i; k++)
                    sk[k] <= '0;
            end else begin
                sk[0] <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k <= i; k++)
                    sk[k] <= sk[k-1];
            end
        end

        assign x_in[i][0] = sk[i];

        for (genvar j = 0; j < N; j++) begin : g_col
            prod_t mul;
            acc_t  p_in;
            acc_t  p_q;

            assign mul = prod_t'(x_in[i][j]) * prod_t'(w_act[i][j]);

            if (i == 0) begin : g_top
                assign p_in = '0;
            end else begin : g_mid
                assign p_in = p_out[i-1][j];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    p_q <= '0;
                else
                    p_q <= p_in + acc_t'(mul);
            end

            assign p_out[i][j] = p_q;

            if (j < N - 1) begin : g_fwd
                elem_t x_q;

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n)
                        x_q <= '0;
                    else
                        x_q <= x_in[i][j];
                end

                assign x_in[i][j+1] = x_q;
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_desk
        if (j == N - 1) begin : g_pass
            assign y_col[j] = p_out[N-1][j];
        end else begin : g_dly
            acc_t dq [N-1-j];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < N - 1 - j; k++)
                        dq[k] <= '0;
                end else begin
                    dq[0] <= p_out[N-1][j];
                    for (int k = 1; k < N - 1 - j; k++)
                        dq[k] <= dq[k-1];
                end
            end

            assign y_col[j] = dq[N-2-j];
        end
    end
endmodule

// File: tb/tb_mat_systolic_array.sv
// Directed bench for mat_systolic_array, N=4, DATA_WIDTH=16.
// Honours MAT_SYSTOLIC_SAT_EN for the overflow expectations.
module tb_mat_systolic_array;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 34;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [N*AW-1:0] out_q [$];
    int              out_cyc [$];

    mat_systolic_array_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    mat_systolic_array #(.N(N), .DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && bus.data_valid_out) begin
            out_q.push_back(bus.data_out);
            out_cyc.push_back(cyc);
        end
    end

    function automatic logic [N*DW-1:0] vec4(input int a, b, c, d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [N*AW-1:0] yvec(input longint a, b, c, d);
        return {34'(d), 34'(c), 34'(b), 34'(a)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_row(input logic [N*DW-1:0] r);
        bus.weight_valid = 1'b1;
        bus.weight_row   = r;
        tick();
        bus.weight_valid = 1'b0;
    endtask

    task automatic swap_wait();
        bus.weight_swap = 1'b1;
        tick();
        bus.weight_swap = 1'b0;
        for (int k = 0; k < 30 && !bus.data_ready_in; k++)
            tick();
        total_cnt++;
        if (bus.data_ready_in !== 1'b1)
            $display("FAIL swap_timeout: ready=%b want 1", bus.data_ready_in);
        else
            pass_cnt++;
    endtask

    task automatic send_vec(input logic [N*DW-1:0] v, output int acc);
        for (int k = 0; k < 30 && !bus.data_ready_in; k++)
            tick();
        bus.data_valid_in = 1'b1;
        bus.data_in       = v;
        tick();
        acc = cyc;
        bus.data_valid_in = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 40 && out_q.size() < n; k++)
            tick();
    endtask

    task automatic pop_out(output logic [N*AW-1:0] v, output int c);
        if (out_q.size() > 0) begin
            v = out_q.pop_front();
            c = out_cyc.pop_front();
        end else begin
            v = 'x;
            c = -1;
        end
    endtask

    task automatic test_reset();
        bus.weight_valid  = 1'b0;
        bus.weight_row    = '0;
        bus.weight_swap   = 1'b0;
        bus.data_valid_in = 1'b0;
        bus.data_in       = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if (bus.weights_loaded !== 1'b0)
            $display("FAIL rst_loaded: got %b want 0", bus.weights_loaded);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_ready_in !== 1'b0)
            $display("FAIL rst_dready: got %b want 0", bus.data_ready_in);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_valid_out !== 1'b0)
            $display("FAIL rst_dvalid: got %b want 0", bus.data_valid_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_out !== '0)
            $display("FAIL rst_dout: got %h want 0", bus.data_out);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (bus.weight_ready !== 1'b1)
            $display("FAIL rst_wready: got %b want 1", bus.weight_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_ready_in !== 1'b0)
            $display("FAIL unloaded_dready: got %b want 0", bus.data_ready_in);
        else pass_cnt++;
    endtask

    task automatic test_ones();
        logic [N*AW-1:0] got;
        int acc, oc;
        for (int r = 0; r < N; r++)
            load_row(vec4(1, 1, 1, 1));
        swap_wait();
        total_cnt++;
        if (bus.weights_loaded !== 1'b1)
            $display("FAIL ones_loaded: got %b want 1", bus.weights_loaded);
        else pass_cnt++;
        send_vec(vec4(5, 5, 5, 5), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== yvec(20, 20, 20, 20))
            $display("FAIL ones_y: got %h want %h", got, yvec(20, 20, 20, 20));
        else pass_cnt++;
        total_cnt++;
        if (oc - acc !== 8)
            $display("FAIL ones_latency: got %0d want 8", oc - acc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [N*AW-1:0] g0, g1;
        int a0, c0, c1;
        load_row(vec4(1, 0, 0, 0));
        load_row(vec4(0, 1, 0, 0));
        load_row(vec4(0, 0, 1, 0));
        load_row(vec4(0, 0, 0, 1));
        swap_wait();
        bus.data_valid_in = 1'b1;
        bus.data_in = vec4(1, 2, 3, 4);
        tick();
        a0 = cyc;
        bus.data_in = vec4(5, 6, 7, 8);
        tick();
        bus.data_valid_in = 1'b0;
        wait_out(2);
        pop_out(g0, c0);
        pop_out(g1, c1);
        total_cnt++;
        if (g0 !== yvec(1, 2, 3, 4))
            $display("FAIL b2b_y0: got %h want %h", g0, yvec(1, 2, 3, 4));
        else pass_cnt++;
        total_cnt++;
        if (g1 !== yvec(5, 6, 7, 8))
            $display("FAIL b2b_y1: got %h want %h", g1, yvec(5, 6, 7, 8));
        else pass_cnt++;
        total_cnt++;
        if (c0 - a0 !== 8)
            $display("FAIL b2b_latency: got %0d want 8", c0 - a0);
        else pass_cnt++;
        total_cnt++;
        if (c1 - c0 !== 1)
            $display("FAIL b2b_spacing: got %0d want 1", c1 - c0);
        else pass_cnt++;
    endtask

    task automatic test_swap_midstream();
        int  vidx [$];
        bit  useb [$];
        int  accc [$];
        int  nacc = 0;
        int  k = 0;
        int  first_b = -1;
        int  last_a_out = -1;
        int  oc;
        logic rdy;
        logic [N*AW-1:0] got, exp;
        longint s;
        bus.data_valid_in = 1'b1;
        while (nacc < 8 && k < 60) begin
            bus.data_in      = vec4(nacc + 1, nacc + 2, nacc + 3, nacc + 4);
            bus.weight_valid = (k < 4);
            bus.weight_row   = vec4(2, 2, 2, 2);
            bus.weight_swap  = (k == 4);
            rdy = bus.data_ready_in;
            tick();
            if (rdy) begin
                vidx.push_back(nacc);
                useb.push_back(k > 4);
                accc.push_back(cyc);
                nacc++;
            end
            k++;
        end
        bus.data_valid_in = 1'b0;
        bus.weight_valid  = 1'b0;
        bus.weight_swap   = 1'b0;
        wait_out(8);
        total_cnt++;
        if (out_q.size() !== 8)
            $display("FAIL mid_count: got %0d want 8", out_q.size());
        else pass_cnt++;
        for (int i = 0; i < vidx.size(); i++) begin
            pop_out(got, oc);
            if (useb[i]) begin
                s = 2 * (4 * vidx[i] + 10);
                exp = yvec(s, s, s, s);
                if (first_b < 0) first_b = accc[i];
            end else begin
                exp = yvec(vidx[i] + 1, vidx[i] + 2, vidx[i] + 3, vidx[i] + 4);
                last_a_out = oc;
            end
            total_cnt++;
            if (got !== exp)
                $display("FAIL mid_y%0d: got %h want %h", i, got, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (!(first_b > last_a_out))
            $display("FAIL mid_drain: first B accept %0d, last A out %0d",
                     first_b, last_a_out);
        else pass_cnt++;
    endtask

    task automatic test_short_swap();
        logic [N*AW-1:0] got;
        int acc, oc;
        for (int r = 0; r < 3; r++)
            load_row(vec4(3, 3, 3, 3));
        bus.weight_swap = 1'b1;
        tick();
        bus.weight_swap = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (bus.weights_loaded !== 1'b1)
            $display("FAIL short_loaded: got %b want 1", bus.weights_loaded);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_ready_in !== 1'b1)
            $display("FAIL short_dready: got %b want 1", bus.data_ready_in);
        else pass_cnt++;
        send_vec(vec4(1, 2, 3, 4), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== yvec(20, 20, 20, 20))
            $display("FAIL short_y: got %h want %h", got, yvec(20, 20, 20, 20));
        else pass_cnt++;
        load_row(vec4(3, 3, 3, 3));
        total_cnt++;
        if (bus.weight_ready !== 1'b0)
            $display("FAIL full_wready: got %b want 0", bus.weight_ready);
        else pass_cnt++;
        swap_wait();
        send_vec(vec4(1, 2, 3, 4), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== yvec(30, 30, 30, 30))
            $display("FAIL fourth_row_y: got %h want %h", got, yvec(30, 30, 30, 30));
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [N*AW-1:0] got, ep, en;
        int acc, oc;
`ifdef MAT_SYSTOLIC_SAT_EN
        ep = yvec(32767, 32767, 32767, 32767);
        en = yvec(-32768, -32768, -32768, -32768);
`else
        ep = yvec(64'sd4294705156, 64'sd4294705156,
                  64'sd4294705156, 64'sd4294705156);
        en = yvec(-64'sd4294836224, -64'sd4294836224,
                  -64'sd4294836224, -64'sd4294836224);
`endif
        for (int r = 0; r < N; r++)
            load_row(vec4(32767, 32767, 32767, 32767));
        swap_wait();
        send_vec(vec4(32767, 32767, 32767, 32767), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== ep)
            $display("FAIL ovf_pos: got %h want %h", got, ep);
        else pass_cnt++;
        send_vec(vec4(-32768, -32768, -32768, -32768), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== en)
            $display("FAIL ovf_neg: got %h want %h", got, en);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        logic [N*AW-1:0] got;
        int acc, oc;
        load_row(vec4(9, 9, 9, 9));
        load_row(vec4(9, 9, 9, 9));
        bus.data_valid_in = 1'b1;
        bus.data_in = vec4(1, 1, 1, 1);
        tick();
        tick();
        bus.data_valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.weights_loaded !== 1'b0)
            $display("FAIL mrst_loaded: got %b want 0", bus.weights_loaded);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_ready_in !== 1'b0)
            $display("FAIL mrst_dready: got %b want 0", bus.data_ready_in);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_valid_out !== 1'b0)
            $display("FAIL mrst_dvalid: got %b want 0", bus.data_valid_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_out !== '0)
            $display("FAIL mrst_dout: got %h want 0", bus.data_out);
        else pass_cnt++;
        out_q.delete();
        out_cyc.delete();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        total_cnt++;
        if (out_q.size() !== 0)
            $display("FAIL mrst_ghost: got %0d results want 0", out_q.size());
        else pass_cnt++;
        total_cnt++;
        if (bus.weight_ready !== 1'b1)
            $display("FAIL mrst_wready: got %b want 1", bus.weight_ready);
        else pass_cnt++;
        load_row(vec4(1, 0, 0, 0));
        load_row(vec4(0, 2, 0, 0));
        load_row(vec4(0, 0, 3, 0));
        load_row(vec4(0, 0, 0, 4));
        swap_wait();
        send_vec(vec4(1, 1, 1, 1), acc);
        wait_out(1);
        pop_out(got, oc);
        total_cnt++;
        if (got !== yvec(1, 2, 3, 4))
            $display("FAIL mrst_reload_y: got %h want %h", got, yvec(1, 2, 3, 4));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_back_to_back();
        test_swap_midstream();
        test_short_swap();
        test_overflow();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
